// File: rtl/ptp_pkg.sv
// ptp_pkg: shared constants and FSM state type for the PTP Sync transmitter
// Holds the Ethernet/PTP field constants, packet-bus word markers and the
// word-sequencer state enum used by ptp_sync_tx.
package ptp_pkg;
    localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
    localparam logic [47:0] PTP_DA_MCAST  = 48'h011B19000000;
    localparam logic [3:0]  MSG_SYNC      = 4'h0;
    localparam logic [7:0]  PTP_VERSION   = 8'h02;
    localparam logic [15:0] SYNC_MSG_LEN  = 16'h002C;
    localparam logic [1:0]  MARK_HEAD     = 2'b01;
    localparam logic [1:0]  MARK_MID      = 2'b11;
    localparam logic [1:0]  MARK_TAIL     = 2'b10;
    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;
endpackage

// File: rtl/ptp_sync_tx_if.sv
// ptp_sync_tx_if: 134-bit packet-bus output channel with backpressure
// tx_ready             downstream not-almost-full
// pktout_data_wr       data word strobe
// pktout_data          {marker[1:0], invalid_bytes[3:0], data[127:0]}
// pktout_data_valid_wr pulses with the tail word
// pktout_data_valid    frame-good flag
interface ptp_sync_tx_if;
    logic         tx_ready;
    logic         pktout_data_wr;
    logic [133:0] pktout_data;
    logic         pktout_data_valid_wr;
    logic         pktout_data_valid;
    modport master (input tx_ready, output pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid);
    modport slave (output tx_ready, input pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid);
endinterface

// File: rtl/ptp_interval_timer.sv
// ptp_interval_timer: Sync trigger timer with pending flag and overrun counter
// clk, rst_n      clock, async active-low reset
// sync_en         global enable
// sync_interval   cycles between triggers, 0 disables
// device_role     current PTP role, counts only when MASTER_ROLE
// done            frame completion, clears pending
// tc              terminal count this cycle
// pending         a frame is owed
// overrun_cnt     triggers lost while pending, saturating
module ptp_interval_timer #(
    parameter logic [1:0] MASTER_ROLE = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync_en,
    input  logic [31:0] sync_interval,
    input  logic [1:0]  device_role,
    input  logic        done,
    output logic        tc,
    output logic        pending,
    output logic [15:0] overrun_cnt
);
    logic [31:0] cnt;
    logic        active;
    assign active = sync_en && device_role == MASTER_ROLE && sync_interval != 32'd0;
    // >= keeps the counter from running past a shortened interval
    assign tc = active && cnt >= sync_interval - 32'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            cnt     <= (active && !tc) ? cnt + 32'd1 : 32'd0;
            // a trigger coinciding with completion re-arms instead of counting as lost
            pending <= tc || (pending && !done);
            if (tc && pending && !done && overrun_cnt != 16'hFFFF)
                overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/ptp_sync_tx.sv
// ptp_sync_tx: periodic IEEE 1588 Sync frame generator on the 134-bit packet bus
// clk, rst_n      clock, async active-low reset
// sync_en         global enable, sampled at frame start
// sync_interval   cycles between Sync triggers, 0 disables
// device_mac      source MAC / clock identity seed, latched at frame start
// device_role     PTP role, frames only when MASTER_ROLE
// precision_time  local time, latched when the head word leaves
// overrun_cnt     triggers lost while a frame was pending
// bus             packet-bus master (ptp_sync_tx_if)
// PTP_SYNC_TWO_STEP_EN: two-step mode, adds tx_ts_valid/tx_ts and zeroes the inline timestamp
module ptp_sync_tx
    import ptp_pkg::*;
#(
    parameter logic [1:0]  MASTER_ROLE = 2'b01,
    parameter logic [15:0] SEQ_INIT    = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_en,
    input  logic [31:0]   sync_interval,
    input  logic [47:0]   device_mac,
    input  logic [1:0]    device_role,
    input  logic [47:0]   precision_time,
    output logic [15:0]   overrun_cnt,
`ifdef PTP_SYNC_TWO_STEP_EN
    output logic          tx_ts_valid,
    output logic [47:0]   tx_ts,
`endif
    ptp_sync_tx_if.master bus
);
    state_t       state, state_d;
    logic [15:0]  seq;
    logic [47:0]  mac_l, ts_l, ts_field;
    logic [15:0]  flags;
    logic         tc, pending, done, start, wr_d, vwr_d;
    logic [133:0] data_d;
    logic [127:0] w0, w1, w2, w3;

    ptp_interval_timer #(.MASTER_ROLE(MASTER_ROLE)) u_timer (
        .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .sync_interval(sync_interval),
        .device_role(device_role), .done(done), .tc(tc), .pending(pending),
        .overrun_cnt(overrun_cnt)
    );

`ifdef PTP_SYNC_TWO_STEP_EN
    assign flags    = 16'h0200;
    assign ts_field = '0;
`else
    assign flags    = 16'h0000;
    assign ts_field = ts_l;
`endif

    // state Wn means word n is on the bus this cycle; W3 is the tail cycle
    assign done  = state == W3;
    // a trigger this cycle starts the frame directly so the head follows terminal count by one cycle
    assign start = state == IDLE && (pending || tc) && bus.tx_ready && sync_en && device_role == MASTER_ROLE;

    assign w0 = {PTP_DA_MCAST, device_mac, PTP_ETHERTYPE, 4'h0, MSG_SYNC, PTP_VERSION};
    assign w1 = {SYNC_MSG_LEN, 8'h00, 8'h00, flags, 64'd0, 16'd0};
    assign w2 = {16'd0, mac_l[47:24], 16'hFFFE, mac_l[23:0], 16'h0001, seq, 8'h00, 8'h00};
    assign w3 = {32'd0, ts_field, 16'd0, 32'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        wr_d    = 1'b0;
        vwr_d   = 1'b0;
        data_d  = bus.pktout_data;
        case (state)
            IDLE: if (start) begin
                state_d = W0;
                wr_d    = 1'b1;
                data_d  = {MARK_HEAD, 4'd0, w0};
            end
            W0: if (bus.tx_ready) begin
                state_d = W1;
                wr_d    = 1'b1;
                data_d  = {MARK_MID, 4'd0, w1};
            end
            W1: if (bus.tx_ready) begin
                state_d = W2;
                wr_d    = 1'b1;
                data_d  = {MARK_MID, 4'd0, w2};
            end
            W2: if (bus.tx_ready) begin
                state_d = W3;
                wr_d    = 1'b1;
                vwr_d   = 1'b1;
                data_d  = {MARK_TAIL, 4'd4, w3};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq                      <= SEQ_INIT;
            mac_l                    <= '0;
            ts_l                     <= '0;
            bus.pktout_data_wr       <= 1'b0;
            bus.pktout_data          <= '0;
            bus.pktout_data_valid_wr <= 1'b0;
            bus.pktout_data_valid    <= 1'b0;
        end else begin
            bus.pktout_data_wr       <= wr_d;
            bus.pktout_data          <= data_d;
            bus.pktout_data_valid_wr <= vwr_d;
            bus.pktout_data_valid    <= vwr_d;
            if (start) begin
                mac_l <= device_mac;
                ts_l  <= precision_time;
            end
            if (done) seq <= seq + 16'd1;
        end
    end

`ifdef PTP_SYNC_TWO_STEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ts_valid <= 1'b0;
            tx_ts       <= '0;
        end else begin
            tx_ts_valid <= vwr_d;
            if (vwr_d) tx_ts <= ts_l;
        end
    end
`endif
endmodule

// File: tb/tb_ptp_sync_tx.sv
// tb_ptp_sync_tx: scoreboard bench for ptp_sync_tx (two instances, SEQ_INIT 0000 and FFFF)
module tb_ptp_sync_tx;
    typedef struct {
        int           cyc;
        logic [133:0] d;
        logic         v;
    } exp_t;

    logic        clk = 0, rst_n = 1, sync_en = 0, tx_ready = 0;
    logic [31:0] sync_interval = 0;
    logic [47:0] device_mac = 48'h000A35010203, precision_time = 0;
    logic [1:0]  device_role = 2'b01;
    logic [15:0] ovr0, ovr1;
    int checks = 0, failures = 0, cyc = 0;
    exp_t q0[$], q1[$];
    logic [15:0] seqs0[$], seqs1[$];
    int heads = 0, last_head = 0, wrs = 0, idx0 = 0, idx1 = 0;
    bit phase_a = 0, got_first = 0;
    logic [133:0] first_head;

    ptp_sync_tx_if bus0 ();
    ptp_sync_tx_if bus1 ();
    assign bus0.tx_ready = tx_ready;
    assign bus1.tx_ready = tx_ready;

`ifdef PTP_SYNC_TWO_STEP_EN
    logic        tv0, tv1;
    logic [47:0] tt0, tt1;
`endif

    ptp_sync_tx dut0 (
        .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .sync_interval(sync_interval),
        .device_mac(device_mac), .device_role(device_role), .precision_time(precision_time),
        .overrun_cnt(ovr0),
`ifdef PTP_SYNC_TWO_STEP_EN
        .tx_ts_valid(tv0), .tx_ts(tt0),
`endif
        .bus(bus0)
    );

    ptp_sync_tx #(.SEQ_INIT(16'hFFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .sync_interval(sync_interval),
        .device_mac(device_mac), .device_role(device_role), .precision_time(precision_time),
        .overrun_cnt(ovr1),
`ifdef PTP_SYNC_TWO_STEP_EN
        .tx_ts_valid(tv1), .tx_ts(tt1),
`endif
        .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic fail(input string s);
        checks++;
        failures++;
        $display("FAIL %s", s);
    endtask

    task automatic chk(input string nm, input logic [133:0] got, input logic [133:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Frame built byte by byte from the published layout, then cut into 16-byte words
    function automatic logic [133:0] exp_word(input logic [47:0] mac, input logic [15:0] seq,
                                              input logic [47:0] ts, input int n);
        logic [7:0]   b [64];
        logic [127:0] w;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        b[0] = 8'h01; b[1] = 8'h1B; b[2] = 8'h19;
        for (int i = 0; i < 6; i++) b[6 + i] = mac[47 - 8*i -: 8];
        b[12] = 8'h88; b[13] = 8'hF7; b[14] = 8'h00; b[15] = 8'h02;
        b[16] = 8'h00; b[17] = 8'h2C;
`ifdef PTP_SYNC_TWO_STEP_EN
        b[20] = 8'h02;
`else
        for (int i = 0; i < 6; i++) b[52 + i] = ts[47 - 8*i -: 8];
`endif
        for (int i = 0; i < 3; i++) b[34 + i] = mac[47 - 8*i -: 8];
        b[37] = 8'hFF; b[38] = 8'hFE;
        for (int i = 0; i < 3; i++) b[39 + i] = mac[23 - 8*i -: 8];
        b[42] = 8'h00; b[43] = 8'h01;
        b[44] = seq[15:8]; b[45] = seq[7:0];
        for (int i = 0; i < 16; i++) w[127 - 8*i -: 8] = b[16*n + i];
        return {(n == 0) ? 2'b01 : (n == 3) ? 2'b10 : 2'b11, (n == 3) ? 4'd4 : 4'd0, w};
    endfunction

    // Reference model: a trigger every sync_interval enabled cycles; at most one frame owed;
    // a trigger while a frame is owed (and not just finishing) is lost and counted.
    int          m_since, m_pos;
    bit          m_owed, m_act, m_trig, m_fin;
    logic [15:0] m_nfr, m_ovr;
    logic [47:0] m_mac, m_ts;

    task automatic expect_word(input int n);
        q0.push_back(exp_t'{cyc, exp_word(m_mac, m_nfr, m_ts, n), n == 3});
        q1.push_back(exp_t'{cyc, exp_word(m_mac, 16'hFFFF + m_nfr, m_ts, n), n == 3});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since = 0; m_pos = -1; m_owed = 0; m_nfr = 0; m_ovr = 0;
            q0.delete(); q1.delete();
        end else begin
            cyc++;
            m_act  = sync_en && device_role == 2'b01 && sync_interval != 0;
            m_trig = m_act && (m_since + 1 == int'(sync_interval));
            m_fin  = m_pos == 3;
            if (m_pos < 0 && (m_owed || m_trig) && tx_ready && sync_en && device_role == 2'b01) begin
                m_mac = device_mac;
                m_ts  = precision_time;
                m_pos = 0;
                expect_word(0);
            end else if (m_pos >= 0 && m_pos < 3 && tx_ready) begin
                m_pos++;
                expect_word(m_pos);
            end else if (m_fin) begin
                m_pos = -1;
                m_nfr++;
            end
            if (m_trig) begin
                if (m_owed && !m_fin && m_ovr != 16'hFFFF) m_ovr++;
                m_owed = 1;
            end else if (m_fin) m_owed = 0;
            m_since = (m_act && !m_trig) ? m_since + 1 : 0;
        end
    end

    task automatic mon(input int k, input logic wr, input logic vwr, input logic v, input logic [133:0] d);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            if (k == 0) e = q0[0];
            else e = q1[0];
        end
        if (vwr && !wr) fail($sformatf("valid_wr_without_word bus%0d", k));
        if (wr && n == 0) fail($sformatf("unexpected_word bus%0d got=%h cycle=%0d", k, d, cyc));
        else if (wr || (n > 0 && e.cyc <= cyc)) begin
            if (k == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            if (!wr) fail($sformatf("missing_word bus%0d want=%h at_cycle=%0d", k, e.d, e.cyc));
            else begin
                chk($sformatf("word_data bus%0d", k), d, e.d);
                chk($sformatf("word_cycle bus%0d", k), cyc, e.cyc);
                chk($sformatf("valid_wr bus%0d", k), vwr, e.v);
                chk($sformatf("valid_flag bus%0d", k), v, e.v);
            end
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        mon(0, bus0.pktout_data_wr, bus0.pktout_data_valid_wr, bus0.pktout_data_valid, bus0.pktout_data);
        mon(1, bus1.pktout_data_wr, bus1.pktout_data_valid_wr, bus1.pktout_data_valid, bus1.pktout_data);
        if (bus0.pktout_data_wr) begin
            wrs++;
            if (bus0.pktout_data[133:132] == 2'b01) begin
                heads++;
                if (phase_a && last_head != 0) chk("head_spacing", cyc - last_head, 100);
                last_head = cyc;
                if (!got_first) begin
                    first_head = bus0.pktout_data;
                    got_first  = 1;
                end
                idx0 = 0;
            end else idx0++;
            if (idx0 == 2) seqs0.push_back(bus0.pktout_data[31:16]);
        end
        if (bus1.pktout_data_wr) begin
            if (bus1.pktout_data[133:132] == 2'b01) idx1 = 0;
            else idx1++;
            if (idx1 == 2) seqs1.push_back(bus1.pktout_data[31:16]);
        end
`ifdef PTP_SYNC_TWO_STEP_EN
        if (bus0.pktout_data_valid_wr) chk("tx_ts", {tv0, tt0}, {1'b1, m_ts});
`endif
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            precision_time += 48'd8;
        end
    endtask

    task automatic wait_head(input int lim);
        int i = 0;
        while (!(bus0.pktout_data_wr && bus0.pktout_data[133:132] == 2'b01) && i < lim) begin
            tick(1);
            i++;
        end
        if (i >= lim) fail("head_timeout");
    endtask

    initial begin
        #2 rst_n = 0;
        #10;
        chk("reset_data", bus0.pktout_data, 0);
        chk("reset_wr", bus0.pktout_data_wr, 0);
        chk("reset_valid_wr", bus0.pktout_data_valid_wr, 0);
        chk("reset_valid", bus0.pktout_data_valid, 0);
        chk("reset_overrun", ovr0, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        sync_interval = 100; sync_en = 1; tx_ready = 1; phase_a = 1;
        tick(350);
        phase_a = 0;
        chk("heads_interval100", heads, 3);
        chk("first_head_word", first_head, {2'b01, 4'd0, 128'h011B19000000_000A35010203_88F7_0002});
        chk("seq_frames_a", seqs0.size(), 3);
        chk("seq_frames_a_ffff", seqs1.size(), 3);
        if (seqs0.size() >= 2 && seqs1.size() >= 2) begin
            chk("seq_first", seqs0[0], 16'h0000);
            chk("seq_second", seqs0[1], 16'h0001);
            chk("seq_init_ffff_first", seqs1[0], 16'hFFFF);
            chk("seq_init_ffff_second", seqs1[1], 16'h0000);
        end
        // randomized traffic, backpressure and MAC churn
        sync_en = 0;
        tick(1);
        sync_interval = $urandom_range(6, 30);
        sync_en = 1;
        for (int i = 0; i < 1500; i++) begin
            tick(1);
            tx_ready   = $urandom_range(0, 3) != 0;
            device_mac = {16'($urandom), 32'($urandom)};
            sync_en    = $urandom_range(0, 49) != 0;
            if (!sync_en) sync_interval = $urandom_range(6, 30);
        end
        sync_en = 1; tx_ready = 1; sync_interval = 20;
        wait_head(100);
        tick(1);
        tx_ready = 0;
        tick(2);
        tx_ready = 1;
        tick(8);
        chk("overrun_random", ovr0, m_ovr);
        chk("overrun_random_ffff", ovr1, m_ovr);
        // overrun under sustained backpressure
        sync_en = 0;
        rst_n = 0;
        tick(2);
        rst_n = 1; sync_interval = 2; sync_en = 1; tx_ready = 0; device_role = 2'b01;
        tick(20);
        chk("overrun_9", ovr0, 9);
        chk("overrun_model", ovr0, m_ovr);
        heads = 0;
        sync_interval = 0; tx_ready = 1;
        tick(30);
        chk("one_frame_after_release", heads, 1);
        // no output when not master or interval disabled
        wrs = 0;
        device_role = 2'b10; sync_interval = 50;
        tick(10000);
        chk("silent_role10", wrs, 0);
        device_role = 2'b01; sync_interval = 0;
        tick(10000);
        chk("silent_interval0", wrs, 0);
        // reset while word 1 is on the bus
        sync_interval = 10;
        wait_head(50);
        tick(1);
        rst_n = 0;
        #1;
        chk("rst_mid_data", bus0.pktout_data, 0);
        chk("rst_mid_wr", bus0.pktout_data_wr, 0);
        chk("rst_mid_valid_wr", bus0.pktout_data_valid_wr, 0);
        chk("rst_mid_overrun", ovr0, 0);
        chk("rst_mid_data_ffff", bus1.pktout_data, 0);
        seqs0.delete();
        seqs1.delete();
        tick(2);
        rst_n = 1;
        tick(25);
        chk("seq_after_reset_cnt", seqs0.size(), 2);
        chk("seq_after_reset_cnt_ffff", seqs1.size(), 2);
        if (seqs0.size() >= 2 && seqs1.size() >= 2) begin
            chk("seq_after_reset", seqs0[0], 16'h0000);
            chk("seq_after_reset_next", seqs0[1], 16'h0001);
            chk("seq_after_reset_ffff", seqs1[0], 16'hFFFF);
            chk("seq_wrap_ffff", seqs1[1], 16'h0000);
        end
        sync_en = 0;
        tick(10);
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
